wb_trace_buffer: RTL

WB_TRACE_BUFFER -- requirements
Module: wb_trace_buffer

---
 rtl/wb_trace_buffer.sv | 91 +++++++++
 1 files changed

// File: rtl/wb_trace_buffer.sv
// Write-back commit trace FIFO (first-word-fall-through) with occupancy, sticky overflow and commit counter.
// Latency: push-to-valid 1 cycle; head fields combinational from storage. Optional macro TRACE_X0_FILTER_EN drops x0 writes.
// Backpressure: trace_ready_i pops the head; commits arriving while full without a pop are dropped and flag overflow_o.
module wb_trace_buffer #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     regfile_we_i,
  input  logic                     stall_wb_i,
  input  logic [4:0]               regfile_waddr_i,
  input  logic [31:0]              regfile_wdata_i,
  input  logic [31:0]              pc_wb_i,
  output logic                     trace_valid_o,
  input  logic                     trace_ready_i,
  output logic [31:0]              trace_pc_o,
  output logic [4:0]               trace_waddr_o,
  output logic [31:0]              trace_wdata_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     overflow_o,
  output logic [31:0]              commit_cnt_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } trace_ent_t;

  trace_ent_t    mem [DEPTH];
  trace_ent_t    head;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] head_idx;
  logic [AW:0]   level;
  logic          commit;
  logic          full;
  logic          pop;
  logic          push;

`ifdef TRACE_X0_FILTER_EN
  assign commit = regfile_we_i & ~stall_wb_i & (regfile_waddr_i != 5'd0);
`else
  assign commit = regfile_we_i & ~stall_wb_i;
`endif

  // A pop frees the slot in the same edge, so push+pop at full is accepted.
  assign full = (level == FULL_LVL);
  assign pop  = (level != '0) & trace_ready_i;
  assign push = commit & (~full | pop);

  // When empty, point at the last popped slot so the head holds its last value.
  assign head_idx = (level == '0) ? rd_ptr - AW'(1) : rd_ptr;
  assign head     = mem[head_idx];

  always_ff @(posedge clk) begin
    if (resetn && push) begin
      mem[wr_ptr] <= '{pc: pc_wb_i, waddr: regfile_waddr_i, wdata: regfile_wdata_i};
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level        <= '0;
      overflow_o   <= 1'b0;
      commit_cnt_o <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
      if (commit && full && !pop) overflow_o <= 1'b1;
      if (commit) commit_cnt_o <= commit_cnt_o + 32'd1;
    end
  end

  assign trace_valid_o = (level != '0);
  assign level_o       = level;
  assign trace_pc_o    = head.pc;
  assign trace_waddr_o = head.waddr;
  assign trace_wdata_o = head.wdata;

endmodule
